// File: rtl/adc_scan_sequencer.sv
// Paced round-robin scan scheduler for an 8-channel serial ADC receiver.
// Tags each returned result with the channel of the preceding config word.
module adc_scan_sequencer #(
    parameter int SAMPLE_PERIOD  = 5000,
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [7:0]  i_chan_mask,
    input  logic        i_unipolar,
    output logic [5:0]  o_tx_bits,
    output logic        o_convert_en,
    input  logic        i_rx_dv,
    input  logic [11:0] i_rx_data,
    output logic        o_sample_dv,
    output logic [11:0] o_sample_data,
    output logic [2:0]  o_sample_chan,
    output logic        o_scan_done,
    output logic        o_overrun,
    output logic        o_timeout
);
    localparam int TW = $clog2(SAMPLE_PERIOD) + 1;
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [OW-1:0] TO_LIMIT  = OW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT_TICK, START, WAIT_DV} state_t;

    state_t        state;
    logic [TW-1:0] tick_ctr;
    logic [OW-1:0] to_ctr;
    logic [2:0]    cur_chan;
    logic [2:0]    prev_chan;
    logic [2:0]    pick;
    logic [2:0]    top_chan;
    logic          prev_valid;
    logic          tick;

    function automatic logic [5:0] cfg_word(input logic [2:0] c, input logic uni);
        return {1'b1, c[0], c[2], c[1], uni, 1'b0};
    endfunction

    assign tick = i_enable && (state != IDLE) && (tick_ctr == TICK_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            tick_ctr <= '0;
        else if (state == IDLE)
            tick_ctr <= '0;
        else if (i_enable)
            tick_ctr <= tick ? '0 : tick_ctr + 1'b1;
    end

    // Lowest offset wins, so scanning resumes just after the last channel picked.
    always_comb begin
        pick = cur_chan;
        for (int k = 8; k >= 1; k--) begin
            if (i_chan_mask[cur_chan + 3'(k)])
                pick = cur_chan + 3'(k);
        end
    end

    always_comb begin
        top_chan = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (i_chan_mask[i])
                top_chan = 3'(i);
        end
    end

    assign o_scan_done = o_sample_dv && (|i_chan_mask) && (o_sample_chan == top_chan);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            cur_chan      <= 3'd7;
            prev_chan     <= 3'd0;
            prev_valid    <= 1'b0;
            to_ctr        <= '0;
            o_tx_bits     <= '0;
            o_convert_en  <= 1'b0;
            o_sample_dv   <= 1'b0;
            o_sample_data <= '0;
            o_sample_chan <= '0;
            o_overrun     <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            o_convert_en <= 1'b0;
            o_sample_dv  <= 1'b0;
            o_overrun    <= 1'b0;
            o_timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_enable)
                        state <= WAIT_TICK;
                end
                WAIT_TICK: begin
                    if (!i_enable) begin
                        state      <= IDLE;
                        prev_valid <= 1'b0;
                    end else if (tick && (|i_chan_mask)) begin
                        prev_chan    <= cur_chan;
                        cur_chan     <= pick;
                        o_tx_bits    <= cfg_word(pick, i_unipolar);
                        o_convert_en <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    o_overrun <= tick;
                    to_ctr    <= '0;
                    state     <= WAIT_DV;
                end
                WAIT_DV: begin
                    o_overrun <= tick;
                    if (i_rx_dv || (to_ctr == TO_LIMIT)) begin
                        // dv takes priority over a timeout landing on the same cycle
                        if (i_rx_dv) begin
                            o_sample_dv <= prev_valid;
                            if (prev_valid) begin
                                o_sample_data <= i_rx_data;
                                o_sample_chan <= prev_chan;
                            end
                        end else begin
                            o_timeout <= 1'b1;
                        end
                        prev_valid <= i_rx_dv && i_enable;
                        state      <= i_enable ? WAIT_TICK : IDLE;
                    end else begin
                        to_ctr <= to_ctr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Scoreboard bench for adc_scan_sequencer: a behavioural ADC returns the previous
// word's channel, expected tagged samples are queued at dv time and popped on output.
module tb_adc_scan_sequencer;
    localparam int SP = 20;
    localparam int TO = 19;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic [7:0]  i_chan_mask;
    logic        i_unipolar;
    logic [5:0]  o_tx_bits;
    logic        o_convert_en;
    logic        i_rx_dv;
    logic [11:0] i_rx_data;
    logic        o_sample_dv;
    logic [11:0] o_sample_data;
    logic [2:0]  o_sample_chan;
    logic        o_scan_done;
    logic        o_overrun;
    logic        o_timeout;

    adc_scan_sequencer #(.SAMPLE_PERIOD(SP), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(i_enable), .i_chan_mask(i_chan_mask),
        .i_unipolar(i_unipolar), .o_tx_bits(o_tx_bits), .o_convert_en(o_convert_en),
        .i_rx_dv(i_rx_dv), .i_rx_data(i_rx_data), .o_sample_dv(o_sample_dv),
        .o_sample_data(o_sample_data), .o_sample_chan(o_sample_chan),
        .o_scan_done(o_scan_done), .o_overrun(o_overrun), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  chan;
        logic [11:0] data;
    } samp_t;

    samp_t      sbq[$];
    samp_t      s;
    int         n_run = 0, n_fail = 0;
    int         cyc = 0, n_conv = 0, n_samp = 0, n_done = 0, n_ovr = 0, n_to = 0;
    int         last_conv = -1, conv_cyc = 0;
    int         rx_delay = 3, rx_cnt = -1;
    bit         rx_mute = 0, chk_period = 0, sb_prev_valid = 0;
    logic [2:0] tb_chan = 3'd7;
    logic [2:0] rx_tag = 3'd0;
    logic [5:0] rx_prev_word = 6'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] cfg(input logic [2:0] c, input logic u);
        return {1'b1, c[0], c[2], c[1], u, 1'b0};
    endfunction

    function automatic logic [2:0] next_chan(input logic [2:0] cur, input logic [7:0] m);
        logic [2:0] c = cur;
        for (int k = 0; k < 8; k++) begin
            c = c + 3'd1;
            if (m[c]) return c;
        end
        return cur;
    endfunction

    function automatic logic [2:0] highest(input logic [7:0] m);
        logic [2:0] h = 3'd0;
        for (int i = 0; i < 8; i++) if (m[i]) h = 3'(i);
        return h;
    endfunction

    // ADC model and output monitor, all on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            rx_cnt = -1; sb_prev_valid = 0; tb_chan = 3'd7; i_rx_dv = 0;
            last_conv = -1; sbq.delete();
        end else begin
            if (o_sample_dv) begin
                n_samp++;
                if (o_scan_done) n_done++;
                if (sbq.size() == 0) begin
                    chk("unexpected_sample", 1, 0);
                end else begin
                    s = sbq.pop_front();
                    chk("samp_chan", o_sample_chan, s.chan);
                    chk("samp_data", o_sample_data, s.data);
                    chk("scan_done", o_scan_done, (|i_chan_mask) && (s.chan == highest(i_chan_mask)));
                end
            end else if (o_scan_done) begin
                chk("scan_done_stray", 1, 0);
            end
            if (o_overrun) n_ovr++;
            if (o_timeout) begin
                n_to++;
                chk("timeout_latency", cyc - conv_cyc, TO + 2);
            end
            i_rx_dv = 0;
            if (o_convert_en) begin
                n_conv++;
                if (chk_period && last_conv >= 0) chk("conv_period", cyc - last_conv, SP);
                last_conv = cyc;
                conv_cyc  = cyc;
                tb_chan   = next_chan(tb_chan, i_chan_mask);
                chk("tx_bits", o_tx_bits, cfg(tb_chan, i_unipolar));
                rx_tag       = {rx_prev_word[3], rx_prev_word[2], rx_prev_word[4]};
                rx_prev_word = o_tx_bits;
                if (rx_mute) begin
                    rx_cnt = -1; sb_prev_valid = 0;
                end else begin
                    rx_cnt = rx_delay;
                end
            end else if (rx_cnt > 0) begin
                rx_cnt--;
                if (rx_cnt == 0) begin
                    i_rx_dv   = 1;
                    i_rx_data = 12'h100 + 12'(rx_tag);
                    if (sb_prev_valid) sbq.push_back({rx_tag, 12'h100 + 12'(rx_tag)});
                    sb_prev_valid = i_enable;
                    rx_cnt = -1;
                end
            end
            if (!i_enable && rx_cnt < 0) sb_prev_valid = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic wait_conv(input int n, input string tag);
        int target = n_conv + n;
        int k = 0;
        while (n_conv < target && k < 20 * SP) begin
            @(negedge clk);
            k++;
        end
        #2;
        if (n_conv < target) chk({"wait_", tag}, n_conv, target);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_tx"},    o_tx_bits, 0);
        chk({tag, "_conv"},  o_convert_en, 0);
        chk({tag, "_sdv"},   o_sample_dv, 0);
        chk({tag, "_sdata"}, o_sample_data, 0);
        chk({tag, "_schan"}, o_sample_chan, 0);
        chk({tag, "_done"},  o_scan_done, 0);
        chk({tag, "_ovr"},   o_overrun, 0);
        chk({tag, "_to"},    o_timeout, 0);
    endtask

    int c0, s0, o0, t0;

    initial begin
        rst = 1; i_enable = 0; i_chan_mask = 8'h00; i_unipolar = 0;
        i_rx_dv = 0; i_rx_data = 12'h000;
        step(3);
        chk_outputs_zero("reset");
        rst = 0;
        step(2);

        // 1: mask 05 -> first result discarded, then ch0,ch2,... tagged samples
        i_chan_mask = 8'h05; i_enable = 1;
        s0 = n_samp;
        wait_conv(5, "t1");
        step(6);
        chk("t1_samples", n_samp - s0, 4);
        chk("t1_scan_done", n_done, 2);
        chk("t1_queue", sbq.size(), 0);

        // 2: all channels, fixed conversion period
        i_chan_mask = 8'hFF; i_unipolar = 1; chk_period = 1;
        wait_conv(10, "t2");
        chk_period = 0;
        step(6);
        chk("t2_queue", sbq.size(), 0);

        // 3: receiver silent -> timeout, next result discarded
        rx_mute = 1; t0 = n_to;
        for (int k = 0; k < 4 * SP && n_to == t0; k++) step(1);
        chk("t3_timeout_seen", n_to - t0, 1);
        rx_mute = 0; s0 = n_samp;
        wait_conv(2, "t3");
        step(6);
        chk("t3_samples", n_samp - s0, 1);

        // 4: dv arrives after the next tick, on the timeout-limit cycle
        rx_delay = 20; o0 = n_ovr; t0 = n_to; s0 = n_samp;
        wait_conv(1, "t4");
        step(25);
        rx_delay = 3;
        chk("t4_overrun", n_ovr - o0, 1);
        chk("t4_no_timeout", n_to - t0, 0);
        chk("t4_samples", n_samp - s0, 1);

        // 5: empty mask, then only channel 7
        i_chan_mask = 8'h00; step(6); c0 = n_conv;
        step(5 * SP);
        chk("t5_no_conv", n_conv - c0, 0);
        i_chan_mask = 8'h80; s0 = n_samp;
        wait_conv(3, "t5");
        step(6);
        chk("t5_samples", n_samp - s0, 3);
        chk("t5_queue", sbq.size(), 0);

        // 6a: disable mid-conversion delivers the in-flight sample, then stops
        rx_delay = 8;
        wait_conv(1, "t6a");
        step(3);
        i_enable = 0; s0 = n_samp; c0 = n_conv;
        step(3 * SP);
        chk("t6a_delivered", n_samp - s0, 1);
        chk("t6a_no_conv", n_conv - c0, 0);
        i_enable = 1; s0 = n_samp;
        wait_conv(2, "t6a_re");
        step(10);
        chk("t6a_re_samples", n_samp - s0, 1);

        // 6b: reset mid-conversion aborts everything
        wait_conv(1, "t6b");
        step(3);
        rst = 1;
        step(1);
        chk_outputs_zero("t6b_reset");
        i_enable = 0;
        step(2);
        rst = 0; c0 = n_conv; s0 = n_samp;
        step(2 * SP);
        chk("t6b_no_conv", n_conv - c0, 0);
        chk("t6b_no_samp", n_samp - s0, 0);
        chk("final_queue", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
